// File: rtl/rib_pkg.sv
// Shared RIB protocol definitions: bus widths, master ID type and arbiter state encoding.
package rib_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef logic mid_t;
  localparam mid_t MID0 = 1'b0;
  localparam mid_t MID1 = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rib_id_fifo.sv
// Small FIFO of master IDs, one entry per accepted-but-unanswered request.
module rib_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly at DEPTH so a depth of 1 also works.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rib_arb2.sv
// Two-master RIB arbiter: round-robin request selection with hold-until-granted,
// and in-order response routing through an ID FIFO of outstanding transactions.
module rib_arb2
  import rib_pkg::*;
#(
  parameter int OST_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic [ADDR_W-1:0] i_rib0_addr,
  input  logic              i_rib0_wrcs,
  input  logic [MASK_W-1:0] i_rib0_mask,
  input  logic [DATA_W-1:0] i_rib0_wdata,
  input  logic              i_rib0_req,
  output logic              o_rib0_gnt,
  output logic [DATA_W-1:0] o_rib0_rdata,
  output logic              o_rib0_rsp,
  input  logic              i_rib0_rdy,

  input  logic [ADDR_W-1:0] i_rib1_addr,
  input  logic              i_rib1_wrcs,
  input  logic [MASK_W-1:0] i_rib1_mask,
  input  logic [DATA_W-1:0] i_rib1_wdata,
  input  logic              i_rib1_req,
  output logic              o_rib1_gnt,
  output logic [DATA_W-1:0] o_rib1_rdata,
  output logic              o_rib1_rsp,
  input  logic              i_rib1_rdy,

  output logic [ADDR_W-1:0] o_ribs_addr,
  output logic              o_ribs_wrcs,
  output logic [MASK_W-1:0] o_ribs_mask,
  output logic [DATA_W-1:0] o_ribs_wdata,
  output logic              o_ribs_req,
  input  logic              i_ribs_gnt,
  input  logic [DATA_W-1:0] i_ribs_rdata,
  input  logic              i_ribs_rsp,
  output logic              o_ribs_rdy
);

  arb_state_t state;
  mid_t       sel;
  mid_t       rr;
  mid_t       cur;
  logic       cur_valid;
  logic       cur_req;
  logic       req_xfer;

  logic       fifo_full;
  logic       fifo_empty;
  mid_t       fifo_head;
  logic       rsp_valid;
  logic       rsp_xfer;

  // Reset is folded in here so outputs already look idle during reset cycles.
  always_comb begin
    cur       = MID0;
    cur_valid = 1'b0;
    if (!i_rst) begin
      if (state == ST_LOCK) begin
        cur       = sel;
        cur_valid = 1'b1;
      end else if (i_rib0_req && i_rib1_req) begin
        cur       = rr;
        cur_valid = 1'b1;
      end else if (i_rib1_req) begin
        cur       = MID1;
        cur_valid = 1'b1;
      end else if (i_rib0_req) begin
        cur       = MID0;
        cur_valid = 1'b1;
      end
    end
  end

  assign cur_req    = cur_valid & ((cur == MID1) ? i_rib1_req : i_rib0_req);
  assign o_ribs_req = cur_req & ~fifo_full;
  assign req_xfer   = o_ribs_req & i_ribs_gnt;
  assign o_rib0_gnt = req_xfer & (cur == MID0);
  assign o_rib1_gnt = req_xfer & (cur == MID1);

  always_comb begin
    o_ribs_addr  = '0;
    o_ribs_wrcs  = 1'b0;
    o_ribs_mask  = '0;
    o_ribs_wdata = '0;
    if (cur_valid) begin
      if (cur == MID1) begin
        o_ribs_addr  = i_rib1_addr;
        o_ribs_wrcs  = i_rib1_wrcs;
        o_ribs_mask  = i_rib1_mask;
        o_ribs_wdata = i_rib1_wdata;
      end else begin
        o_ribs_addr  = i_rib0_addr;
        o_ribs_wrcs  = i_rib0_wrcs;
        o_ribs_mask  = i_rib0_mask;
        o_ribs_wdata = i_rib0_wdata;
      end
    end
  end

  assign rsp_valid    = ~i_rst & ~fifo_empty;
  assign o_ribs_rdy   = rsp_valid & ((fifo_head == MID1) ? i_rib1_rdy : i_rib0_rdy);
  assign rsp_xfer     = i_ribs_rsp & o_ribs_rdy;
  assign o_rib0_rsp   = rsp_valid & (fifo_head == MID0) & i_ribs_rsp;
  assign o_rib1_rsp   = rsp_valid & (fifo_head == MID1) & i_ribs_rsp;
  assign o_rib0_rdata = (rsp_valid && fifo_head == MID0) ? i_ribs_rdata : '0;
  assign o_rib1_rdata = (rsp_valid && fifo_head == MID1) ? i_ribs_rdata : '0;

  // A selection that misses its grant is frozen until it transfers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      sel   <= MID0;
      rr    <= MID0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cur_valid && !req_xfer) begin
            state <= ST_LOCK;
            sel   <= cur;
          end
        end
        ST_LOCK: begin
          if (req_xfer) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (req_xfer) begin
        rr <= ~cur;
      end
    end
  end

  rib_id_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_id_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (req_xfer),
    .pop   (rsp_xfer),
    .din   (cur),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_rib_arb2.sv
// Directed testbench for rib_arb2: reset, round-robin, lock, outstanding limit,
// in-order response routing and reset with transactions in flight.
module tb_rib_arb2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_rib0_addr, i_rib1_addr, i_rib0_wdata, i_rib1_wdata, i_ribs_rdata;
  logic [3:0]  i_rib0_mask, i_rib1_mask;
  logic        i_rib0_wrcs, i_rib1_wrcs, i_rib0_req, i_rib1_req, i_rib0_rdy, i_rib1_rdy;
  logic        i_ribs_gnt, i_ribs_rsp;
  logic        o_rib0_gnt, o_rib1_gnt, o_rib0_rsp, o_rib1_rsp;
  logic [31:0] o_rib0_rdata, o_rib1_rdata, o_ribs_addr, o_ribs_wdata;
  logic [3:0]  o_ribs_mask;
  logic        o_ribs_wrcs, o_ribs_req, o_ribs_rdy;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  rib_arb2 #(.OST_DEPTH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rib0_addr(i_rib0_addr), .i_rib0_wrcs(i_rib0_wrcs), .i_rib0_mask(i_rib0_mask),
    .i_rib0_wdata(i_rib0_wdata), .i_rib0_req(i_rib0_req), .o_rib0_gnt(o_rib0_gnt),
    .o_rib0_rdata(o_rib0_rdata), .o_rib0_rsp(o_rib0_rsp), .i_rib0_rdy(i_rib0_rdy),
    .i_rib1_addr(i_rib1_addr), .i_rib1_wrcs(i_rib1_wrcs), .i_rib1_mask(i_rib1_mask),
    .i_rib1_wdata(i_rib1_wdata), .i_rib1_req(i_rib1_req), .o_rib1_gnt(o_rib1_gnt),
    .o_rib1_rdata(o_rib1_rdata), .o_rib1_rsp(o_rib1_rsp), .i_rib1_rdy(i_rib1_rdy),
    .o_ribs_addr(o_ribs_addr), .o_ribs_wrcs(o_ribs_wrcs), .o_ribs_mask(o_ribs_mask),
    .o_ribs_wdata(o_ribs_wdata), .o_ribs_req(o_ribs_req), .i_ribs_gnt(i_ribs_gnt),
    .i_ribs_rdata(i_ribs_rdata), .i_ribs_rsp(i_ribs_rsp), .o_ribs_rdy(o_ribs_rdy)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_rib0_addr = '0; i_rib0_wrcs = 0; i_rib0_mask = '0; i_rib0_wdata = '0; i_rib0_req = 0; i_rib0_rdy = 0;
    i_rib1_addr = '0; i_rib1_wrcs = 0; i_rib1_mask = '0; i_rib1_wdata = '0; i_rib1_req = 0; i_rib1_rdy = 0;
    i_ribs_gnt = 0; i_ribs_rsp = 0; i_ribs_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst = 1;
    tick();
    tick();
    i_rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1;
    i_rib0_req = 1; i_rib0_addr = 32'h1234; i_rib1_req = 1; i_rib1_addr = 32'h5678;
    i_ribs_gnt = 1; i_ribs_rsp = 1; i_ribs_rdata = 32'hDEAD; i_rib0_rdy = 1; i_rib1_rdy = 1;
    tick();
    @(negedge i_clk);
    if (o_ribs_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", o_ribs_req); end checks++;
    if (o_rib0_gnt !== 1'b0 || o_rib1_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b want 00", o_rib0_gnt, o_rib1_gnt); end checks++;
    if (o_ribs_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", o_ribs_addr); end checks++;
    if (o_ribs_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", o_ribs_rdy); end checks++;
    if (o_rib0_rsp !== 1'b0 || o_rib1_rsp !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %b%b want 00", o_rib0_rsp, o_rib1_rsp); end checks++;
    if (o_rib0_rdata !== 32'h0 || o_rib1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h %h want 0 0", o_rib0_rdata, o_rib1_rdata); end checks++;
    do_reset();
  endtask

  task automatic test_round_robin();
    logic exp0;
    do_reset();
    i_rib0_req = 1; i_rib0_addr = 32'h100; i_rib1_req = 1; i_rib1_addr = 32'h200;
    i_ribs_gnt = 1; i_ribs_rsp = 1; i_ribs_rdata = 32'h77; i_rib0_rdy = 1; i_rib1_rdy = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      exp0 = (k % 2 == 0);
      if (o_rib0_gnt !== exp0) begin errors++; $display("FAIL rr_gnt0 cyc%0d: got %b want %b", k, o_rib0_gnt, exp0); end checks++;
      if (o_rib1_gnt !== !exp0) begin errors++; $display("FAIL rr_gnt1 cyc%0d: got %b want %b", k, o_rib1_gnt, !exp0); end checks++;
      if (o_ribs_addr !== (exp0 ? 32'h100 : 32'h200)) begin errors++; $display("FAIL rr_addr cyc%0d: got %h", k, o_ribs_addr); end checks++;
      if (k == 0) begin
        if (o_ribs_rdy !== 1'b0 || o_rib0_rsp !== 1'b0) begin errors++; $display("FAIL rr_empty_rsp: got rdy=%b rsp0=%b want 0 0", o_ribs_rdy, o_rib0_rsp); end checks++;
      end else begin
        // Head of the FIFO is the master granted the previous cycle.
        if (o_rib0_rsp !== !exp0 || o_rib1_rsp !== exp0) begin errors++; $display("FAIL rr_rsp cyc%0d: got %b%b", k, o_rib0_rsp, o_rib1_rsp); end checks++;
      end
      tick();
    end
    do_reset();
  endtask

  task automatic test_lock();
    do_reset();
    i_rib0_req = 1; i_rib0_addr = 32'h10; i_ribs_gnt = 1; i_ribs_rsp = 1; i_rib0_rdy = 1; i_rib1_rdy = 1;
    @(negedge i_clk);
    if (o_rib0_gnt !== 1'b1) begin errors++; $display("FAIL lock_first_gnt: got %b want 1", o_rib0_gnt); end checks++;
    tick();
    i_rib0_addr = 32'hF100_0000; i_rib0_wrcs = 1; i_ribs_gnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin i_rib1_req = 1; i_rib1_addr = 32'h2000; end
      if (k == 3) i_ribs_gnt = 1;
      @(negedge i_clk);
      if (o_ribs_addr !== 32'hF100_0000) begin errors++; $display("FAIL lock_addr cyc%0d: got %h want f1000000", k, o_ribs_addr); end checks++;
      if (o_ribs_wrcs !== 1'b1) begin errors++; $display("FAIL lock_wrcs cyc%0d: got %b want 1", k, o_ribs_wrcs); end checks++;
      if (o_rib1_gnt !== 1'b0) begin errors++; $display("FAIL lock_gnt1 cyc%0d: got %b want 0", k, o_rib1_gnt); end checks++;
      if (o_rib0_gnt !== (k == 3)) begin errors++; $display("FAIL lock_gnt0 cyc%0d: got %b want %b", k, o_rib0_gnt, (k == 3)); end checks++;
      tick();
    end
    i_rib0_req = 0;
    @(negedge i_clk);
    if (o_rib1_gnt !== 1'b1 || o_ribs_addr !== 32'h2000) begin errors++; $display("FAIL lock_release: got gnt1=%b addr=%h want 1 2000", o_rib1_gnt, o_ribs_addr); end checks++;
    do_reset();
  endtask

  task automatic test_outstanding();
    do_reset();
    i_rib0_req = 1; i_ribs_gnt = 1; i_rib0_rdy = 1; i_rib1_rdy = 1;
    @(negedge i_clk);
    if (o_rib0_gnt !== 1'b1) begin errors++; $display("FAIL ost_gnt_a: got %b want 1", o_rib0_gnt); end checks++;
    tick();
    i_rib0_req = 0; i_rib1_req = 1;
    @(negedge i_clk);
    if (o_rib1_gnt !== 1'b1) begin errors++; $display("FAIL ost_gnt_b: got %b want 1", o_rib1_gnt); end checks++;
    tick();
    i_rib0_req = 1; i_rib1_req = 0;
    for (int k = 0; k < 3; k++) begin
      i_ribs_rsp = (k == 2);
      @(negedge i_clk);
      if (o_ribs_req !== 1'b0 || o_rib0_gnt !== 1'b0) begin errors++; $display("FAIL ost_full cyc%0d: got req=%b gnt0=%b want 0 0", k, o_ribs_req, o_rib0_gnt); end checks++;
      if (o_ribs_rdy !== 1'b1) begin errors++; $display("FAIL ost_rdy cyc%0d: got %b want 1", k, o_ribs_rdy); end checks++;
      tick();
    end
    i_ribs_rsp = 0;
    @(negedge i_clk);
    if (o_ribs_req !== 1'b1 || o_rib0_gnt !== 1'b1) begin errors++; $display("FAIL ost_resume: got req=%b gnt0=%b want 1 1", o_ribs_req, o_rib0_gnt); end checks++;
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_rib0_req = 1; i_ribs_gnt = 1;
    tick();
    i_rib0_req = 0; i_rib1_req = 1;
    tick();
    i_rib1_req = 0; i_ribs_gnt = 0;
    i_ribs_rsp = 1; i_ribs_rdata = 32'hAAAA_AAAA; i_rib0_rdy = 0; i_rib1_rdy = 1;
    @(negedge i_clk);
    if (o_ribs_rdy !== 1'b0) begin errors++; $display("FAIL order_stall_rdy: got %b want 0", o_ribs_rdy); end checks++;
    if (o_rib0_rsp !== 1'b1 || o_rib0_rdata !== 32'hAAAA_AAAA) begin errors++; $display("FAIL order_stall_m0: got rsp=%b data=%h", o_rib0_rsp, o_rib0_rdata); end checks++;
    if (o_rib1_rsp !== 1'b0 || o_rib1_rdata !== 32'h0) begin errors++; $display("FAIL order_stall_m1: got rsp=%b data=%h want 0 0", o_rib1_rsp, o_rib1_rdata); end checks++;
    tick();
    i_rib0_rdy = 1;
    @(negedge i_clk);
    if (o_ribs_rdy !== 1'b1 || o_rib0_rdata !== 32'hAAAA_AAAA) begin errors++; $display("FAIL order_m0: got rdy=%b data=%h", o_ribs_rdy, o_rib0_rdata); end checks++;
    tick();
    i_ribs_rdata = 32'h5555_5555;
    @(negedge i_clk);
    if (o_rib1_rsp !== 1'b1 || o_rib1_rdata !== 32'h5555_5555) begin errors++; $display("FAIL order_m1: got rsp=%b data=%h", o_rib1_rsp, o_rib1_rdata); end checks++;
    if (o_rib0_rsp !== 1'b0 || o_rib0_rdata !== 32'h0) begin errors++; $display("FAIL order_m0_quiet: got rsp=%b data=%h want 0 0", o_rib0_rsp, o_rib0_rdata); end checks++;
    tick();
    @(negedge i_clk);
    if (o_rib1_rsp !== 1'b0 || o_ribs_rdy !== 1'b0) begin errors++; $display("FAIL order_drained: got rsp1=%b rdy=%b want 0 0", o_rib1_rsp, o_ribs_rdy); end checks++;
    do_reset();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    i_rib0_req = 1; i_ribs_gnt = 1; i_rib0_rdy = 1; i_rib1_rdy = 1;
    tick();
    i_rib0_req = 0; i_rib1_req = 1;
    tick();
    i_rib1_req = 0; i_rst = 1; i_ribs_rsp = 1; i_ribs_rdata = 32'hCAFE;
    @(negedge i_clk);
    if (o_ribs_rdy !== 1'b0 || o_rib0_rsp !== 1'b0) begin errors++; $display("FAIL midrst_during: got rdy=%b rsp0=%b want 0 0", o_ribs_rdy, o_rib0_rsp); end checks++;
    tick();
    i_rst = 0; i_ribs_rdata = 32'h1234; i_rib0_req = 1; i_rib1_req = 1;
    i_rib0_addr = 32'hA0; i_rib1_addr = 32'hB0;
    @(negedge i_clk);
    if (o_rib0_rsp !== 1'b0 || o_rib1_rsp !== 1'b0 || o_ribs_rdy !== 1'b0) begin errors++; $display("FAIL midrst_late_rsp: got %b%b rdy=%b want 00 0", o_rib0_rsp, o_rib1_rsp, o_ribs_rdy); end checks++;
    if (o_rib0_rdata !== 32'h0 || o_rib1_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h %h want 0 0", o_rib0_rdata, o_rib1_rdata); end checks++;
    if (o_rib0_gnt !== 1'b1 || o_rib1_gnt !== 1'b0 || o_ribs_addr !== 32'hA0) begin errors++; $display("FAIL midrst_priority: got gnt=%b%b addr=%h want 10 a0", o_rib0_gnt, o_rib1_gnt, o_ribs_addr); end checks++;
    do_reset();
  endtask

  initial begin
    idle_inputs();
    i_rst = 1;
    test_reset();
    test_round_robin();
    test_lock();
    test_outstanding();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
